// File: rtl/lc3_mem_pkg.sv
// Shared types and constants for the LC-3 main-memory arbiter slice.
// States, requester IDs and default widths/timeouts live here so top and arbiter agree.
package lc3_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DMA = 1'b1;

  localparam int DEFAULT_TIMEOUT = 16;
  localparam int LC3_ADDR_W      = 16;
  localparam int LC3_DATA_W      = 16;

endpackage

// File: rtl/lc3_rr_arbiter2.sv
// Two-requester round-robin pick: on a tie the requester not served last wins.
module lc3_rr_arbiter2
  import lc3_mem_pkg::*;
(
  input  logic cpu_req,
  input  logic dma_req,
  input  logic last_grant,
  output logic any_req,
  output logic grant
);

  always_comb begin
    any_req = cpu_req | dma_req;
    grant   = REQ_CPU;
    if (cpu_req && dma_req)
      grant = (last_grant == REQ_CPU) ? REQ_DMA : REQ_CPU;
    else if (dma_req)
      grant = REQ_DMA;
  end

endmodule

// File: rtl/lc3_mem_arbiter.sv
// Shares the single-port LC-3 main memory between the CPU and a DMA/loader port,
// running one complete access at a time with a timeout watchdog.
module lc3_mem_arbiter
  import lc3_mem_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int ADDR_W  = LC3_ADDR_W,
  parameter int DATA_W  = LC3_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  output logic              cpu_err,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_ready,
  output logic              dma_err,
  output logic              mem_en,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_r
);

  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT);

  state_t            state;
  logic [7:0]        cnt;
  logic              grant;
  logic              last_grant;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic              any_req;
  logic              pick;

  lc3_rr_arbiter2 u_arb (
    .cpu_req    (cpu_req),
    .dma_req    (dma_req),
    .last_grant (last_grant),
    .any_req    (any_req),
    .grant      (pick)
  );

  // Memory side depends only on state and latched request, never on live requester inputs.
  assign mem_en    = (state == ACCESS);
  assign mem_rw    = mem_en & lat_we;
  assign mem_addr  = lat_addr;
  assign mem_wdata = lat_wdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      grant      <= REQ_CPU;
      last_grant <= REQ_DMA;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      cpu_rdata  <= '0;
      cpu_ready  <= 1'b0;
      cpu_err    <= 1'b0;
      dma_rdata  <= '0;
      dma_ready  <= 1'b0;
      dma_err    <= 1'b0;
    end else begin
      cpu_ready <= 1'b0;
      cpu_err   <= 1'b0;
      dma_ready <= 1'b0;
      dma_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            grant     <= pick;
            lat_we    <= (pick == REQ_DMA) ? dma_we    : cpu_we;
            lat_addr  <= (pick == REQ_DMA) ? dma_addr  : cpu_addr;
            lat_wdata <= (pick == REQ_DMA) ? dma_wdata : cpu_wdata;
            cnt       <= '0;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          cnt <= cnt + 8'd1;
          // R may be left over from before this access, so it only counts from the second cycle.
          if (cnt != 8'd0 && mem_r) begin
            if (grant == REQ_DMA) begin
              dma_ready <= 1'b1;
              if (!lat_we) dma_rdata <= mem_rdata;
            end else begin
              cpu_ready <= 1'b1;
              if (!lat_we) cpu_rdata <= mem_rdata;
            end
            state <= RESP;
          end else if (cnt + 8'd1 == TO_LIMIT) begin
            if (grant == REQ_DMA) begin
              dma_ready <= 1'b1;
              dma_err   <= 1'b1;
            end else begin
              cpu_ready <= 1'b1;
              cpu_err   <= 1'b1;
            end
            state <= RESP;
          end
        end
        RESP: begin
          last_grant <= grant;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// Scoreboard bench for lc3_mem_arbiter with a behavioural one-cycle LC-3 memory model.
module tb_lc3_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [15:0] cpu_addr = '0, cpu_wdata = '0;
  logic [15:0] cpu_rdata;
  logic        cpu_ready, cpu_err;
  logic        dma_req = 1'b0, dma_we = 1'b0;
  logic [15:0] dma_addr = '0, dma_wdata = '0;
  logic [15:0] dma_rdata;
  logic        dma_ready, dma_err;
  logic        mem_en, mem_rw;
  logic [15:0] mem_addr, mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic        mem_r = 1'b0;

  logic        preload = 1'b1;
  logic        r_block = 1'b0;
  logic [15:0] mem [0:65535];

  int cyc = 0;
  int checks = 0;
  int fails = 0;
  int rw_cycles = 0;
  int done_cnt = 0;

  typedef struct {
    logic        port;
    logic        err;
    logic [15:0] data;
    int          at;
  } exp_t;
  exp_t sb[$];

  lc3_mem_arbiter #(.TIMEOUT(16), .ADDR_W(16), .DATA_W(16)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .cpu_err(cpu_err),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_ready(dma_ready), .dma_err(dma_err),
    .mem_en(mem_en), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_r(mem_r)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory: registered read, R follows MIO_EN one cycle later unless blocked.
  always @(posedge clk) begin
    if (preload) mem[16'h3000] <= 16'h1234;
    else if (mem_en && mem_rw) mem[mem_addr] <= mem_wdata;
    if (mem_en) mem_rdata <= mem[mem_addr];
    mem_r <= mem_en && !r_block;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (mem_rw) rw_cycles++;
    if (cpu_ready || dma_ready) begin
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $display("[TB] FAIL unexpected_ready: cpu_ready=%0b dma_ready=%0b at cycle %0d", cpu_ready, dma_ready, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("ready_port", {31'd0, dma_ready}, {31'd0, e.port});
        checkOutput("single_ready", {31'd0, cpu_ready & dma_ready}, 32'd0);
        checkOutput("err", {31'd0, e.port ? dma_err : cpu_err}, {31'd0, e.err});
        checkOutput("rdata", {16'd0, e.port ? dma_rdata : cpu_rdata}, {16'd0, e.data});
        checkOutput("ready_cycle", cyc, e.at);
      end
      done_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    preload = 1'b0;
  endtask

  // Issue one access, queue its expected response, then drop req in the RESP cycle.
  task automatic applyStimulus(input logic port, input logic we, input logic [15:0] addr,
                               input logic [15:0] wdata, input logic exp_err,
                               input logic [15:0] exp_data, input int lat);
    bit seen = 0;
    sb.push_back('{port: port, err: exp_err, data: exp_data, at: cyc + lat});
    if (port) begin
      dma_req = 1'b1; dma_we = we; dma_addr = addr; dma_wdata = wdata;
    end else begin
      cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    end
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      if (port ? dma_ready : cpu_ready) seen = 1;
    end
    cpu_req = 1'b0;
    dma_req = 1'b0;
    if (!seen) begin
      checks++;
      fails++;
      $display("[TB] FAIL ready_wait: got no ready expected ready within 40 cycles");
    end
    tick();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL global_watchdog: got running expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    doReset();
    checkOutput("rst_mem_en", {31'd0, mem_en}, 32'd0);
    checkOutput("rst_mem_rw", {31'd0, mem_rw}, 32'd0);
    checkOutput("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
    checkOutput("rst_mem_wdata", {16'd0, mem_wdata}, 32'd0);
    checkOutput("rst_cpu_ready", {31'd0, cpu_ready}, 32'd0);
    checkOutput("rst_dma_ready", {31'd0, dma_ready}, 32'd0);
    checkOutput("rst_cpu_err", {31'd0, cpu_err}, 32'd0);
    checkOutput("rst_dma_err", {31'd0, dma_err}, 32'd0);
    checkOutput("rst_cpu_rdata", {16'd0, cpu_rdata}, 32'd0);
    checkOutput("rst_dma_rdata", {16'd0, dma_rdata}, 32'd0);

    $display("[TB] CPU read of x3000");
    applyStimulus(1'b0, 1'b0, 16'h3000, 16'h0000, 1'b0, 16'h1234, 3);

    $display("[TB] DMA write xBEEF to x4000, CPU read back");
    checkOutput("rw_before_write", rw_cycles, 0);
    applyStimulus(1'b1, 1'b1, 16'h4000, 16'hBEEF, 1'b0, 16'h0000, 3);
    checkOutput("rw_after_write", rw_cycles, 2);
    applyStimulus(1'b0, 1'b0, 16'h4000, 16'h0000, 1'b0, 16'hBEEF, 3);
    checkOutput("rw_after_read", rw_cycles, 2);

    $display("[TB] timeout with R held low");
    r_block = 1'b1;
    applyStimulus(1'b0, 1'b0, 16'h3000, 16'h0000, 1'b1, 16'hBEEF, 17);
    r_block = 1'b0;
    tick();
    checkOutput("timeout_idle_mem_en", {31'd0, mem_en}, 32'd0);
    checkOutput("timeout_rdata_kept", {16'd0, cpu_rdata}, 32'h0000BEEF);

    $display("[TB] reset during DMA write");
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'h4100; dma_wdata = 16'h5555;
    tick();
    checkOutput("abort_mem_en_c1", {31'd0, mem_en}, 32'd1);
    tick();
    reset = 1'b1;
    dma_req = 1'b0;
    tick();
    reset = 1'b0;
    checkOutput("abort_mem_en", {31'd0, mem_en}, 32'd0);
    checkOutput("abort_cpu_rdata", {16'd0, cpu_rdata}, 32'd0);
    checkOutput("abort_dma_ready", {31'd0, dma_ready}, 32'd0);
    checkOutput("abort_dma_err", {31'd0, dma_err}, 32'd0);
    tick();
    tick();
    applyStimulus(1'b0, 1'b0, 16'h3000, 16'h0000, 1'b0, 16'h1234, 3);

    $display("[TB] round-robin with both requesters held");
    doReset();
    for (int k = 0; k < 8; k++) begin
      if (k % 2 == 0) sb.push_back('{port: 1'b0, err: 1'b0, data: 16'h1234, at: cyc + 3 + 4 * k});
      else            sb.push_back('{port: 1'b1, err: 1'b0, data: 16'hBEEF, at: cyc + 3 + 4 * k});
    end
    cpu_we = 1'b0; cpu_addr = 16'h3000;
    dma_we = 1'b0; dma_addr = 16'h4000;
    cpu_req = 1'b1;
    dma_req = 1'b1;
    n = 0;
    for (int i = 0; i < 60 && n < 8; i++) begin
      tick();
      if (cpu_ready || dma_ready) n++;
    end
    cpu_req = 1'b0;
    dma_req = 1'b0;
    checkOutput("rr_access_count", n, 8);
    tick();
    tick();
    tick();
    checkOutput("rr_idle_mem_en", {31'd0, mem_en}, 32'd0);
    checkOutput("scoreboard_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
